// File: rtl/sram_controller_pkg.sv
// Shared constants and types for the SRAM controller.
package sram_controller_pkg;

  localparam int REGISTER_LEN     = 32;
  localparam int SRAM_DATA_LEN    = 16;
  localparam int SRAM_ADDR_LEN    = 18;
  localparam int BLOCK_LEN        = 64;
  localparam int MEM_BASE_DEFAULT = 1024;

  // Controller FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Index of the final halfword for each transaction type.
  localparam logic [1:0] READ_LAST_HW  = 2'd3;
  localparam logic [1:0] WRITE_LAST_HW = 2'd1;

endpackage

// File: rtl/sram_access_counter.sv
// Per-halfword cycle counter: counts 0..ACCESS_CYCLES-1, then moves to the next halfword.
module sram_access_counter #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] last_idx,
  output logic [1:0] hw_idx,
  output logic       wrap,
  output logic       last_hw
);

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACCESS_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign wrap    = en && (cnt == CNT_MAX);
  assign last_hw = wrap && (hw_idx == last_idx);

  // Advance the cycle count; bump the halfword index on each wrap, clear while idle.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      cnt    <= '0;
      hw_idx <= '0;
    end else if (!en) begin
      cnt    <= '0;
      hw_idx <= '0;
    end else if (wrap) begin
      cnt    <= '0;
      hw_idx <= hw_idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sram_controller.sv
// 16-bit asynchronous SRAM controller: 8-byte block reads, 32-bit word writes.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int          ACCESS_CYCLES = 2,
  parameter logic [31:0] MEM_BASE      = 32'(MEM_BASE_DEFAULT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_en,
  input  logic                     wr_en,
  input  logic [REGISTER_LEN-1:0]  address,
  input  logic [REGISTER_LEN-1:0]  write_data,
  output logic [BLOCK_LEN-1:0]     read_data,
  output logic                     ready,
  output logic [SRAM_ADDR_LEN-1:0] SRAM_ADDR,
  inout  wire  [SRAM_DATA_LEN-1:0] SRAM_DQ,
  output logic                     SRAM_WE_N,
  output logic                     SRAM_CE_N,
  output logic                     SRAM_OE_N,
  output logic                     SRAM_UB_N,
  output logic                     SRAM_LB_N
);

  state_t state, next_state;

  logic [REGISTER_LEN-1:0]  off;
  logic [16:0]              pair_base;   // word (halfword-pair) index captured in IDLE
  logic [REGISTER_LEN-1:0]  wdata_q;
  logic [47:0]              rd_buf;      // halfwords 0..2 of the block being fetched
  logic [1:0]               hw_idx;
  logic                     wrap;
  logic                     last_hw;
  logic                     dq_en;
  logic [SRAM_DATA_LEN-1:0] dq_out;
  logic                     unused_off_bits;

  assign off             = address - MEM_BASE;
  assign unused_off_bits = ^{off[31:19], off[1:0]};

  sram_access_counter #(
    .ACCESS_CYCLES(ACCESS_CYCLES)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .en       ((state == READ) || (state == WRITE)),
    .last_idx ((state == READ) ? READ_LAST_HW : WRITE_LAST_HW),
    .hw_idx   (hw_idx),
    .wrap     (wrap),
    .last_hw  (last_hw)
  );

  // Next-state logic and SRAM strobes decoded from the current state.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    next_state = state;
    ready      = 1'b0;
    SRAM_WE_N  = 1'b1;
    SRAM_OE_N  = 1'b1;
    dq_en      = 1'b0;
    unique case (state)
      IDLE: begin
        ready = !rd_en && !wr_en;
        if (wr_en)      next_state = WRITE;
        else if (rd_en) next_state = READ;
      end
      READ: begin
        SRAM_OE_N = 1'b0;
        if (last_hw) next_state = DONE;
      end
      WRITE: begin
        SRAM_WE_N = 1'b0;
        dq_en     = 1'b1;
        if (last_hw) next_state = DONE;
      end
      DONE: begin
        ready      = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Halfword address: reads are 8-byte aligned (4 halfwords), writes 4-byte aligned (2 halfwords).
  always_comb begin
    SRAM_ADDR = '0;
    unique case (state)
      READ:    SRAM_ADDR = {pair_base[16:1], hw_idx};
      WRITE:   SRAM_ADDR = {pair_base, hw_idx[0]};
      default: SRAM_ADDR = '0;
    endcase
  end

  assign dq_out    = hw_idx[0] ? wdata_q[31:16] : wdata_q[15:0];
  assign SRAM_DQ   = dq_en ? dq_out : 'z;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  // State register, request capture in IDLE, and read-block assembly.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the read buffer and result are reset too, so a reset read_data is a known 0.
      state     <= IDLE;
      pair_base <= '0;
      wdata_q   <= '0;
      rd_buf    <= '0;
      read_data <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE) begin
        pair_base <= off[18:2];
        wdata_q   <= write_data;
      end
      if ((state == READ) && wrap) begin
        if (last_hw) read_data <= {SRAM_DQ, rd_buf};
        else         rd_buf    <= {SRAM_DQ, rd_buf[47:16]};
      end
    end
  end

endmodule
